// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
// The state encoding is fixed at 3 bits so it can be exported unchanged on the debug port.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_t;

  // The counter must be able to hold the largest of the three cycle limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases the core reset.
// Retries on lock timeout and latches a fault after the retry budget is spent.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 742500,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       locked_stable,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

  pll_seq_state_t   r_state;
  pll_seq_state_t   w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retry;
  logic [1:0]       w_next_retry;
  logic             w_lock_s;
  logic             w_hold_done;
  logic             w_stable_done;
  logic             w_timeout;
  logic             w_cnt_clr;
  logic             r_pll_rst;
  logic             r_sys_reset_n;
  logic             r_locked_stable;
  logic             r_fault;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk_74a),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (w_lock_s)
  );

  assign w_hold_done   = (r_cnt == CNT_W'(RST_HOLD_CYCLES - 1));
  assign w_stable_done = (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1));
  assign w_timeout     = (r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));

  // relock_req overrides every other event; lock loss beats stable completion,
  // and a lock arriving on the timeout cycle beats the timeout.
  always_comb begin
    w_next_state = r_state;
    w_next_retry = r_retry;
    if (relock_req) begin
      w_next_state = RESET_PLL;
      w_next_retry = 2'd0;
    end else begin
      case (r_state)
        RESET_PLL: if (w_hold_done) w_next_state = WAIT_LOCK;
        WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next_state = STABILIZE;
          end else if (w_timeout) begin
            if (r_retry == 2'(MAX_RETRIES)) begin
              w_next_state = FAULT;
            end else begin
              w_next_state = RESET_PLL;
              w_next_retry = r_retry + 2'd1;
            end
          end
        end
        STABILIZE: begin
          if (!w_lock_s) begin
            w_next_state = WAIT_LOCK;
          end else if (w_stable_done) begin
            w_next_state = RUN;
            w_next_retry = 2'd0;
          end
        end
        RUN:     if (!w_lock_s) w_next_state = RESET_PLL;
        FAULT:   w_next_state = FAULT;
        default: w_next_state = RESET_PLL;
      endcase
    end
  end

  assign w_cnt_clr = relock_req || (w_next_state != r_state);

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= RESET_PLL;
      r_cnt           <= '0;
      r_retry         <= 2'd0;
      r_pll_rst       <= 1'b1;
      r_sys_reset_n   <= 1'b0;
      r_locked_stable <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_retry <= w_next_retry;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Outputs decode the next state so they move on the same edge as the state.
      r_pll_rst       <= (w_next_state == RESET_PLL) || (w_next_state == FAULT);
      r_sys_reset_n   <= (w_next_state == RUN);
      r_locked_stable <= (w_next_state == RUN);
      r_fault         <= (w_next_state == FAULT);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_reset_n   = r_sys_reset_n;
  assign locked_stable = r_locked_stable;
  assign fault         = r_fault;
  assign retry_count   = r_retry;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short cycle parameters.
// Edge numbers count rising clk_74a edges since the last reset_n release.
module tb_pll_lock_sequencer;

  localparam int RH = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int MR = 2;

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_STAB  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic       clk_74a = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       locked_stable;
  logic       fault;
  logic [1:0] retry_count;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES     (RH),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (LT),
    .MAX_RETRIES         (MR)
  ) dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .sys_reset_n   (sys_reset_n),
    .locked_stable (locked_stable),
    .fault         (fault),
    .retry_count   (retry_count),
    .state_dbg     (state_dbg)
  );

  // clock / reset block
  always #5 clk_74a = ~clk_74a;

  always @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic pr,
                          input logic sr, input logic ls, input logic ft,
                          input logic [1:0] rc);
    chk({tag, ".state"},         32'(state_dbg),     32'(st));
    chk({tag, ".pll_rst"},       32'(pll_rst),       32'(pr));
    chk({tag, ".sys_reset_n"},   32'(sys_reset_n),   32'(sr));
    chk({tag, ".locked_stable"}, 32'(locked_stable), 32'(ls));
    chk({tag, ".fault"},         32'(fault),         32'(ft));
    chk({tag, ".retry_count"},   32'(retry_count),   32'(rc));
  endtask

  // driver tasks
  task automatic to_edge(input int e);
    while (cyc < e) @(negedge clk_74a);
  endtask

  task automatic do_reset();
    @(negedge clk_74a);
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (2) @(negedge clk_74a);
    reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_outs("por", S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk_74a);
    reset_n = 1'b1;

    // nominal bring-up: lock raised before edge 11, RUN at edge 21
    to_edge(3);
    chk("nom.hold_pll_rst", 32'(pll_rst), 32'd1);
    to_edge(4);
    chk_outs("nom.wait", S_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    to_edge(10);
    pll_locked = 1'b1;
    to_edge(12);
    chk("nom.sync_delay", 32'(state_dbg), 32'(S_WAIT));
    to_edge(13);
    chk("nom.stab_entry", 32'(state_dbg), 32'(S_STAB));
    to_edge(20);
    chk_outs("nom.pre_run", S_STAB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    to_edge(21);
    chk_outs("nom.run", S_RUN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

    // glitchy lock: high 5, low 1, high again before edge 17
    do_reset();
    to_edge(10);
    pll_locked = 1'b1;
    to_edge(15);
    pll_locked = 1'b0;
    to_edge(16);
    pll_locked = 1'b1;
    to_edge(17);
    chk("glitch.stab", 32'(state_dbg), 32'(S_STAB));
    to_edge(18);
    chk("glitch.abort", 32'(state_dbg), 32'(S_WAIT));
    to_edge(19);
    chk("glitch.restab", 32'(state_dbg), 32'(S_STAB));
    to_edge(26);
    chk("glitch.pre_run", 32'(sys_reset_n), 32'd0);
    to_edge(27);
    chk_outs("glitch.run", S_RUN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

    // timeouts to fault: 3 attempts of 36 cycles
    do_reset();
    to_edge(35);
    chk_outs("to.att0_end", S_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    to_edge(36);
    chk_outs("to.retry1", S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    to_edge(39);
    chk("to.pulse1_hi", 32'(pll_rst), 32'd1);
    to_edge(40);
    chk("to.pulse1_lo", 32'(pll_rst), 32'd0);
    to_edge(71);
    chk("to.att1_rc", 32'(retry_count), 32'd1);
    to_edge(72);
    chk_outs("to.retry2", S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    to_edge(76);
    chk("to.att2_wait", 32'(state_dbg), 32'(S_WAIT));
    to_edge(107);
    chk("to.pre_fault", 32'(fault), 32'd0);
    to_edge(108);
    chk_outs("to.fault", S_FAULT, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    to_edge(115);
    chk_outs("to.fault_hold", S_FAULT, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);

    // recovery from fault via relock_req
    relock_req = 1'b1;
    to_edge(116);
    relock_req = 1'b0;
    chk_outs("rec.relock", S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    pll_locked = 1'b1;
    to_edge(120);
    chk("rec.wait", 32'(state_dbg), 32'(S_WAIT));
    to_edge(121);
    chk("rec.stab", 32'(state_dbg), 32'(S_STAB));
    to_edge(128);
    chk("rec.pre_run", 32'(sys_reset_n), 32'd0);
    to_edge(129);
    chk_outs("rec.run", S_RUN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

    // lock loss in RUN: drop before edge 131, reset tree asserted at 133
    to_edge(130);
    pll_locked = 1'b0;
    to_edge(132);
    chk_outs("loss.still_run", S_RUN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    to_edge(133);
    chk_outs("loss.reset", S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    pll_locked = 1'b1;
    to_edge(137);
    chk("loss.wait", 32'(state_dbg), 32'(S_WAIT));
    to_edge(145);
    chk_outs("loss.pre_run", S_STAB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    to_edge(146);
    chk_outs("loss.run", S_RUN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

    // relock_req on the final STABILIZE cycle wins over RUN
    do_reset();
    to_edge(10);
    pll_locked = 1'b1;
    to_edge(20);
    chk("prio.last_stab", 32'(state_dbg), 32'(S_STAB));
    relock_req = 1'b1;
    to_edge(21);
    relock_req = 1'b0;
    chk_outs("prio.relock", S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    to_edge(28);
    chk("prio.stab_again", 32'(state_dbg), 32'(S_STAB));

    // asynchronous reset mid-STABILIZE
    #2 reset_n = 1'b0;
    #1 chk_outs("async.reset", S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk_74a);
    chk("async.held", 32'(state_dbg), 32'(S_RESET));
    reset_n = 1'b1;
    to_edge(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
